frame_scheduler: RTL
====================

Name: frame_scheduler

Overview:
Sequences one frame of fractal rendering: walks the 640x480 raster and dispatches pixel jobs round-robin to NUM_ENGINES iteration engines. It collects their iteration counts back in raster order, maps them to RGB, and drives the pixel packer's r/g/b/valid/sof/eol input with in_stream_ready backpressure. It sits between the engine array and the packer.

Parameters:
NUM_ENGINES, 2, number of iteration engines (power of two, 1..8)
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame
MAX_ITER, 255, iteration count meaning "did not escape"

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
start  in  1  pulse; begins a frame when idle
continuous  in  1  when 1, restart automatically after each frame
busy  out  1  high from frame start until frame_done
frame_done  out  1  one-cycle pulse after last pixel accepted by packer
job_valid  out  NUM_ENGINES  one-hot job request to engine i
job_ready  in  NUM_ENGINES  engine i can accept a job
job_x  out  10  pixel x for the offered job (shared bus)
job_y  out  9  pixel y for the offered job (shared bus)
res_valid  in  NUM_ENGINES  engine i has a result
res_iter  in  8*NUM_ENGINES  iteration count; engine i at [8i+7:8i]
res_ack  out  NUM_ENGINES  result consumed from engine i
r, g, b  out  8 each  pixel colour to packer
valid  out  1  pixel valid to packer
sof  out  1  pixel is (0,0)
eol  out  1  pixel is x = X_SIZE-1
in_stream_ready  in  1  packer accepts pixel

Behaviour:
- Reset (async, immediate): state IDLE; counters and pointers 0; busy, frame_done, valid, sof, eol, job_valid, res_ack = 0; r/g/b = 0.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: dispatching. After job (X_SIZE-1, Y_SIZE-1) is accepted -> DRAIN.
  - DRAIN: collecting only. When the last pixel handshakes with the packer -> frame_done=1 for one cycle, then RUN if continuous=1, else IDLE.
- start while busy is ignored. busy = (state != IDLE).
- Dispatch:
  - In RUN, job_valid = one-hot(issue_ptr); job_x/job_y = dispatch raster counter.
  - Job accepted when job_valid[i] & job_ready[i]. Then advance x; at X_SIZE-1, x wraps to 0 and y increments. issue_ptr = (issue_ptr+1) mod NUM_ENGINES.
  - job_x/job_y are stable while job_valid is held without job_ready.
- Collect:
  - res_ack[collect_ptr] = res_valid[collect_ptr] & (~valid | in_stream_ready), combinational; all other res_ack bits are 0.
  - On ack, register r/g/b from res_iter[collect_ptr], set valid=1, sof=(ox==0 & oy==0), eol=(ox==X_SIZE-1). Advance the collect raster counter and collect_ptr.
  - Engines complete jobs in order, so round-robin collection yields strict raster order regardless of per-engine latency.
- Output hold: while valid & ~in_stream_ready, r/g/b/sof/eol are stable.
  - valid & ready with no new ack -> valid=0 next cycle.
  - Simultaneous handshake and ack -> new pixel loaded with no bubble. Throughput is 1 pixel/cycle.
- Palette: iter==MAX_ITER -> r=g=b=0. Otherwise r=iter, g={iter[6:0],1'b0}, b=~iter.
- Continuous restart: dispatch counters reset to (0,0) on re-entry to RUN. The collect side has already wrapped to (0,0).
- Reset mid-frame: everything is cleared asynchronously. Engines share areset, so no stale results survive. The next start begins at (0,0) with sof.

Decomposition:
- fractal_pkg: X_SIZE, Y_SIZE, X_W=10, Y_W=9, ITER_W=8, state encoding {IDLE, RUN, DRAIN}, palette function.
- Sub-module raster_counter: x/y registers, advance input, first/lastx/last outputs, sync clear. Instantiated twice (dispatch, collect).

Test Plan:
- Nominal frame: 2 engines with 1-cycle latency returning iter=x[7:0]^y[7:0]; ready always 1; one start pulse -> 307200 pixels in raster order; sof only on pixel 0; eol every 640th; one frame_done pulse; busy falls the cycle after.
- Backpressure: in_stream_ready pseudo-random 50% -> no lost or duplicated pixels; r/g/b/sof/eol constant while valid & ~ready.
- Latency skew: engine0 latency 1, engine1 latency 20 -> job_x sequence 0,1,2,3 alternates engines; output remains strict raster order.
- Palette: iter=255 -> (0,0,0); iter=0x81 -> r=0x81, g=0x02, b=0x7E; iter=0 -> (0x00,0x00,0xFF).
- Continuous: continuous=1 -> frame_done twice over two frames; second frame's first pixel has sof=1 at (0,0); start pulse mid-frame has no effect.
- Reset mid-frame after 1000 pixels -> valid, job_valid, busy drop to 0 without waiting for a clock edge; subsequent start -> first output pixel is (0,0) with sof=1.

Source files
------------

// File: rtl/fractal_pkg.sv
// fractal_pkg: shared raster sizes, field widths, scheduler states and the iteration-to-RGB palette.
package fractal_pkg;
    localparam int X_SIZE   = 640;
    localparam int Y_SIZE   = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int ITER_W   = 8;
    localparam int MAX_ITER = 255;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Points that never escaped are drawn black; all other points use a fixed ramp.
    function automatic logic [3*ITER_W-1:0] palette(input logic [ITER_W-1:0] iter, input logic [ITER_W-1:0] max_iter);
        return (iter == max_iter) ? '0 : {iter, iter[ITER_W-2:0], 1'b0, ~iter};
    endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y raster position that steps one pixel per advance and wraps at frame end.
// Ports: clk/rst (async high), clear (sync to 0,0), advance; x, y, first (0,0), lastx (end of line), last (final pixel).
module raster_counter import fractal_pkg::*; #(
    parameter int X_SIZE = fractal_pkg::X_SIZE,
    parameter int Y_SIZE = fractal_pkg::Y_SIZE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           first,
    output logic           lastx,
    output logic           last
);
    assign first = (x == '0) && (y == '0);
    assign lastx = x == X_W'(X_SIZE - 1);
    assign last  = lastx && (y == Y_W'(Y_SIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= lastx ? '0 : x + 1'b1;
            y <= last ? '0 : (lastx ? y + 1'b1 : y);
        end
    end
endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: dispatches one frame of pixel jobs round-robin to the engines and streams coloured results to the packer in raster order.
// Ports: aclk/areset (async high); start/continuous control, busy/frame_done status; job_valid/job_ready/job_x/job_y to engines;
//        res_valid/res_iter/res_ack from engines; r/g/b/valid/sof/eol with in_stream_ready to the packer.
module frame_scheduler import fractal_pkg::*; #(
    parameter int NUM_ENGINES = 2,
    parameter int X_SIZE      = fractal_pkg::X_SIZE,
    parameter int Y_SIZE      = fractal_pkg::Y_SIZE,
    parameter int MAX_ITER    = fractal_pkg::MAX_ITER
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          start,
    input  logic                          continuous,
    output logic                          busy,
    output logic                          frame_done,
    output logic [NUM_ENGINES-1:0]        job_valid,
    input  logic [NUM_ENGINES-1:0]        job_ready,
    output logic [X_W-1:0]                job_x,
    output logic [Y_W-1:0]                job_y,
    input  logic [NUM_ENGINES-1:0]        res_valid,
    input  logic [ITER_W*NUM_ENGINES-1:0] res_iter,
    output logic [NUM_ENGINES-1:0]        res_ack,
    output logic [7:0]                    r,
    output logic [7:0]                    g,
    output logic [7:0]                    b,
    output logic                          valid,
    output logic                          sof,
    output logic                          eol,
    input  logic                          in_stream_ready
);
    localparam int PW = NUM_ENGINES > 1 ? $clog2(NUM_ENGINES) : 1;

    state_t            state, state_next;
    logic [PW-1:0]     issue_ptr, collect_ptr;
    logic              job_fire, ack_fire, done, last_px;
    logic              d_first, d_lastx, d_last, c_first, c_lastx, c_last;
    logic [X_W-1:0]    cx;
    logic [Y_W-1:0]    cy;
    logic [ITER_W-1:0] sel_iter;
    logic              unused_ok;

    raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_dispatch (
        .clk(aclk), .rst(areset), .clear(state != RUN), .advance(job_fire),
        .x(job_x), .y(job_y), .first(d_first), .lastx(d_lastx), .last(d_last)
    );

    // The collect side wraps to (0,0) by itself after the final pixel, so it never needs clearing mid-run.
    raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_collect (
        .clk(aclk), .rst(areset), .clear(state == IDLE), .advance(ack_fire),
        .x(cx), .y(cy), .first(c_first), .lastx(c_lastx), .last(c_last)
    );

    assign unused_ok = ^{d_first, d_lastx, cx, cy};
    assign busy      = state != IDLE;
    assign job_valid = (state == RUN) ? NUM_ENGINES'(1) << issue_ptr : '0;
    assign job_fire  = |(job_valid & job_ready);
    assign sel_iter  = res_iter[ITER_W*int'(collect_ptr) +: ITER_W];
    // A result can be taken whenever the output slot is empty or is being drained this cycle.
    assign ack_fire  = res_valid[collect_ptr] & (~valid | in_stream_ready);
    assign res_ack   = ack_fire ? NUM_ENGINES'(1) << collect_ptr : '0;
    assign done      = (state == DRAIN) & valid & in_stream_ready & last_px;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = (job_fire && d_last) ? DRAIN : RUN;
            default: state_next = done ? (continuous ? RUN : IDLE) : DRAIN;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            issue_ptr   <= '0;
            collect_ptr <= '0;
            frame_done  <= 1'b0;
            valid       <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            last_px     <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else begin
            state      <= state_next;
            frame_done <= done;
            if (job_fire)
                issue_ptr <= (issue_ptr == PW'(NUM_ENGINES - 1)) ? '0 : issue_ptr + 1'b1;
            if (ack_fire) begin
                collect_ptr <= (collect_ptr == PW'(NUM_ENGINES - 1)) ? '0 : collect_ptr + 1'b1;
                {r, g, b}   <= palette(sel_iter, ITER_W'(MAX_ITER));
                valid       <= 1'b1;
                sof         <= c_first;
                eol         <= c_lastx;
                last_px     <= c_last;
            end else if (in_stream_ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule
